// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if
//   Bundles the requester handshake signals and the regfile write-port /
//   scoreboard outputs of regfile_write_arbiter.
//   Ports (signals):
//     Req_Valid     [NREQ]     requester i offers a write
//     Req_Ready     [NREQ]     requester i may hand over its write
//     Req_Addr      [5*NREQ]   destination register of requester i
//     Req_Data      [32*NREQ]  write data of requester i
//     RegWrite      1          regfile write enable
//     WriteRegister 5          regfile write address
//     WriteData     32         regfile write data
//     Pending       32         per-register in-flight write flags
//   Modports: master = requesters/consumer side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    Req_Valid;
    logic [NREQ-1:0]    Req_Ready;
    logic [5*NREQ-1:0]  Req_Addr;
    logic [32*NREQ-1:0] Req_Data;
    logic               RegWrite;
    logic [4:0]         WriteRegister;
    logic [31:0]        WriteData;
    logic [31:0]        Pending;

    modport master (
        output Req_Valid, Req_Addr, Req_Data,
        input  Req_Ready, RegWrite, WriteRegister, WriteData, Pending
    );

    modport slave (
        input  Req_Valid, Req_Addr, Req_Data,
        output Req_Ready, RegWrite, WriteRegister, WriteData, Pending
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//   Shares the single regfile write port among NREQ writeback sources.
//   Each source owns a one-entry holding buffer behind a valid/ready
//   handshake; a round-robin arbiter moves one buffered write per cycle
//   into a registered output stage that drives the regfile. A registered
//   32-bit scoreboard flags every register with a write still in flight.
//   Ports:
//     Clk      in   clock, positive edge
//     Reset_n  in   synchronous active-low reset
//     bus      slave modport of regfile_write_arbiter_if (handshakes,
//              regfile write port, Pending scoreboard)
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    regfile_write_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 2) ? 2 : 1;

    // per-requester buffer views and next-state
    logic [NREQ-1:0] w_full;
    logic [NREQ-1:0] w_full_next;
    logic [NREQ-1:0] w_ready;
    logic [NREQ-1:0] w_grant;
    logic [4:0]      w_buf_addr  [NREQ];
    logic [31:0]     w_buf_data  [NREQ];
    logic [4:0]      w_addr_next [NREQ];

    logic            w_any_grant;
    logic [PW-1:0]   w_ptr_next;
    logic [4:0]      w_sel_addr;
    logic [31:0]     w_sel_data;
    logic [31:0]     w_pending_next;

    logic [PW-1:0]   r_ptr;
    logic            r_regwrite;
    logic [4:0]      r_wreg;
    logic [31:0]     r_wdata;
    logic [31:0]     r_pending;

    // ---------------------------------------------------------------
    // Holding buffers, one per requester
    // ---------------------------------------------------------------
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        logic        r_full;
        logic [4:0]  r_addr;
        logic [31:0] r_data;
        logic [4:0]  w_in_addr;
        logic        w_load;

        assign w_in_addr   = bus.Req_Addr[5*gi +: 5];
        // A granted buffer empties this edge, so it may refill at once.
        assign w_ready[gi] = Reset_n & (~r_full | w_grant[gi]);
        // Writes to r0 complete the handshake but are never buffered.
        assign w_load      = bus.Req_Valid[gi] & w_ready[gi] & (w_in_addr != 5'd0);

        assign w_full_next[gi] = w_load | (r_full & ~w_grant[gi]);
        assign w_addr_next[gi] = w_load ? w_in_addr : r_addr;

        always_ff @(posedge Clk) begin
            if (!Reset_n) begin
                r_full <= 1'b0;
                r_addr <= 5'd0;
                r_data <= 32'd0;
            end else begin
                r_full <= w_full_next[gi];
                if (w_load) begin
                    r_addr <= w_in_addr;
                    r_data <= bus.Req_Data[32*gi +: 32];
                end
            end
        end

        assign w_full[gi]     = r_full;
        assign w_buf_addr[gi] = r_addr;
        assign w_buf_data[gi] = r_data;
    end

    // ---------------------------------------------------------------
    // Round-robin arbitration: first full buffer at or above r_ptr,
    // otherwise the first full buffer below it (wrap-around).
    // ---------------------------------------------------------------
    always_comb begin
        w_grant     = '0;
        w_any_grant = 1'b0;
        w_ptr_next  = r_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_any_grant && w_full[i] && (i >= int'(r_ptr))) begin
                w_grant[i]  = 1'b1;
                w_any_grant = 1'b1;
                w_ptr_next  = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_any_grant && w_full[i]) begin
                w_grant[i]  = 1'b1;
                w_any_grant = 1'b1;
                w_ptr_next  = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    // One-hot grant selects the entry moving to the output stage.
    always_comb begin
        w_sel_addr = 5'd0;
        w_sel_data = 32'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = w_buf_addr[i];
                w_sel_data = w_buf_data[i];
            end
        end
    end

    // Scoreboard reflects the buffers and output stage as they will be
    // after this edge, so a bit drops on the edge the regfile commits.
    always_comb begin
        w_pending_next = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_full_next[i]) begin
                w_pending_next[w_addr_next[i]] = 1'b1;
            end
        end
        if (w_any_grant) begin
            w_pending_next[w_sel_addr] = 1'b1;
        end
        w_pending_next[0] = 1'b0;
    end

    // ---------------------------------------------------------------
    // Pointer, output stage and scoreboard registers
    // ---------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_ptr      <= '0;
            r_regwrite <= 1'b0;
            r_wreg     <= 5'd0;
            r_wdata    <= 32'd0;
            r_pending  <= 32'd0;
        end else begin
            r_ptr      <= w_ptr_next;
            r_regwrite <= w_any_grant;
            if (w_any_grant) begin
                r_wreg  <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
            r_pending  <= w_pending_next;
        end
    end

    assign bus.Req_Ready     = w_ready;
    assign bus.RegWrite      = r_regwrite;
    assign bus.WriteRegister = r_wreg;
    assign bus.WriteData     = r_wdata;
    assign bus.Pending       = r_pending;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//   Directed scenarios followed by randomized traffic. A transaction-level
//   model (per-requester slots, a round-robin pointer, a staged write and
//   per-register in-flight counters) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;
    localparam int NREQ = 2;

    logic clk;
    logic rst_n;

    logic [1:0]  vld;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;

    regfile_write_arbiter_if #(.NREQ(NREQ)) bus();

    assign bus.Req_Valid = vld;
    assign bus.Req_Addr  = {a1, a0};
    assign bus.Req_Data  = {d1, d0};

    regfile_write_arbiter #(.NREQ(NREQ)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    bit          m_full [NREQ];
    logic [4:0]  m_addr [NREQ];
    logic [31:0] m_data [NREQ];
    int          m_ptr;
    bit          m_we;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    int          m_cnt [32];

    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (m_full[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [1:0] model_ready();
        logic [1:0] r;
        int g;
        r = 2'b00;
        g = model_grant();
        if (rst_n) begin
            for (int i = 0; i < NREQ; i++) r[i] = !m_full[i] || (g == i);
        end
        return r;
    endfunction

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = '0;
        for (int r = 0; r < 32; r++) p[r] = (m_cnt[r] > 0);
        return p;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREQ; i++) begin
            m_full[i] = 0; m_addr[i] = '0; m_data[i] = '0;
        end
        m_ptr = 0; m_we = 0; m_wreg = '0; m_wdata = '0;
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        int g;
        logic [1:0] rdy;
        logic [4:0] in_a [NREQ];
        logic [31:0] in_d [NREQ];
        if (!rst_n) begin
            model_clear();
            return;
        end
        in_a[0] = a0; in_a[1] = a1;
        in_d[0] = d0; in_d[1] = d1;
        rdy = model_ready();
        g = model_grant();
        if (m_we) begin
            m_cnt[m_wreg]--;
            $display("[%0t] commit r%0d <= %08h", $time, m_wreg, m_wdata);
        end
        if (g >= 0) begin
            m_we = 1; m_wreg = m_addr[g]; m_wdata = m_data[g];
            m_full[g] = 0;
            m_ptr = (g + 1) % NREQ;
        end else begin
            m_we = 0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (vld[i] && rdy[i] && in_a[i] != 5'd0) begin
                m_full[i] = 1; m_addr[i] = in_a[i]; m_data[i] = in_d[i];
                m_cnt[in_a[i]]++;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("ready",    {30'd0, bus.Req_Ready}, {30'd0, model_ready()});
        chk("regwrite", {31'd0, bus.RegWrite},  {31'd0, m_we});
        chk("wreg",     {27'd0, bus.WriteRegister}, {27'd0, m_wreg});
        chk("wdata",    bus.WriteData, m_wdata);
        chk("pending",  bus.Pending, model_pending());
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        vld = 2'b00; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        model_clear();

        // 1. reset held with both requesters offering
        vld = 2'b11; a0 = 5'd3; d0 = 32'd1; a1 = 5'd4; d1 = 32'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_ready",    {30'd0, bus.Req_Ready}, 32'd0);
            chk("rst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
            chk("rst_pending",  bus.Pending, 32'd0);
        end

        // 3. contention right after reset: pointer starts at requester 0
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("cont_ready", {30'd0, bus.Req_Ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            chk("cont_regwrite", {31'd0, bus.RegWrite}, 32'd1);
            chk("cont_wreg", {27'd0, bus.WriteRegister}, (k % 2 == 0) ? 32'd3 : 32'd4);
            chk("cont_wdata", bus.WriteData, (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        vld = 2'b00;
        for (int k = 0; k < 4; k++) tick();

        // 2. single write
        a0 = 5'd5; d0 = 32'hDEADBEEF; vld = 2'b01;
        tick();
        vld = 2'b00;
        chk("single_pend1", bus.Pending, 32'h0000_0020);
        chk("single_we0",   {31'd0, bus.RegWrite}, 32'd0);
        tick();
        chk("single_we1",   {31'd0, bus.RegWrite}, 32'd1);
        chk("single_wreg",  {27'd0, bus.WriteRegister}, 32'd5);
        chk("single_wdata", bus.WriteData, 32'hDEADBEEF);
        chk("single_pend2", bus.Pending, 32'h0000_0020);
        tick();
        chk("single_we2",   {31'd0, bus.RegWrite}, 32'd0);
        chk("single_pend3", bus.Pending, 32'd0);

        // 4. back-to-back stream from requester 1
        for (int n = 1; n <= 8; n++) begin
            a1 = 5'(n); d1 = 32'h100 + 32'(n); vld = 2'b10;
            chk("b2b_ready", {31'd0, bus.Req_Ready[1]}, 32'd1);
            tick();
            if (n >= 2) chk("b2b_wreg", {27'd0, bus.WriteRegister}, 32'(n - 1));
        end
        vld = 2'b00;
        tick();
        chk("b2b_last_wreg", {27'd0, bus.WriteRegister}, 32'd8);
        chk("b2b_last_we",   {31'd0, bus.RegWrite}, 32'd1);
        tick();
        tick();

        // 5. write to r0 is dropped
        a0 = 5'd0; d0 = 32'hFFFFFFFF; vld = 2'b01;
        chk("r0_ready", {31'd0, bus.Req_Ready[0]}, 32'd1);
        tick();
        vld = 2'b00;
        chk("r0_we",   {31'd0, bus.RegWrite}, 32'd0);
        chk("r0_pend", bus.Pending, 32'd0);
        tick();
        chk("r0_we2",  {31'd0, bus.RegWrite}, 32'd0);

        // 6. reset mid-flight
        a0 = 5'd7; d0 = 32'h7777; a1 = 5'd9; d1 = 32'h9999; vld = 2'b11;
        tick();
        tick();
        chk("mid_we_before", {31'd0, bus.RegWrite}, 32'd1);
        rst_n = 1'b0; vld = 2'b00;
        tick();
        chk("mid_we_after", {31'd0, bus.RegWrite}, 32'd0);
        chk("mid_pend",     bus.Pending, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_quiet_we",   {31'd0, bus.RegWrite}, 32'd0);
            chk("mid_quiet_pend", bus.Pending, 32'd0);
        end

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            vld   = 2'($urandom_range(0, 3));
            a0    = 5'($urandom_range(0, 31));
            a1    = 5'($urandom_range(0, 31));
            d0    = $urandom;
            d1    = $urandom;
            tick();
        end
        rst_n = 1'b1;
        vld = 2'b00;
        for (int k = 0; k < 4; k++) tick();
        chk("drain_pend", bus.Pending, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
